univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg.sv | 131 +++++++++++++
 tb/tb_univ_shift_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Parametrised universal register. It supports hold, parallel load,
//            shift and rotate in both directions, serial in/out and clear. A
//            shift counter produces a one-cycle word-complete pulse after
//            every WIDTH shift/rotate operations.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            en     - clock enable (0 = all state holds, done = 0)
//            mode   - operation select (see c_mode_* below)
//            d      - parallel load data
//            sin    - serial input for the shift modes
//            q      - registered contents
//            sout   - registered copy of the last bit shifted/rotated out
//            cnt    - shift/rotate operations since the last load/clear/wrap
//            done   - one-cycle pulse when a word of WIDTH shifts completes
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin,
  output logic [WIDTH-1:0]             q,
  output logic                         sout,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_mode_hold = 3'b000;
  localparam logic [2:0] c_mode_load = 3'b001;
  localparam logic [2:0] c_mode_shl  = 3'b010;
  localparam logic [2:0] c_mode_shr  = 3'b011;
  localparam logic [2:0] c_mode_rol  = 3'b100;
  localparam logic [2:0] c_mode_ror  = 3'b101;
  localparam logic [2:0] c_mode_clr  = 3'b110;

  // Last value the counter may show; the next step wraps to zero and pulses
  // done, so cnt never exposes WIDTH itself.
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  logic [WIDTH-1:0] q_q,    q_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             done_q, done_d;
  logic             w_step;

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    w_step = 1'b0;

    if (en) begin
      case (mode)
        c_mode_hold: ;
        c_mode_load: begin
          q_d   = d;
          cnt_d = '0;
        end
        c_mode_shl: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
          w_step = 1'b1;
        end
        c_mode_shr: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          w_step = 1'b1;
        end
        c_mode_rol: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
          w_step = 1'b1;
        end
        c_mode_ror: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          w_step = 1'b1;
        end
        c_mode_clr: begin
          q_d    = RESET_VAL;
          cnt_d  = '0;
          sout_d = 1'b0;
        end
        default: ;  // reserved encoding behaves as hold
      endcase

      // Shift and rotate share one counter regardless of direction.
      if (w_step) begin
        if (cnt_q == c_cnt_last) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + c_cnt_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Self-checking bench for univ_shift_reg (WIDTH=4, RESET_VAL=0).
//            An arithmetic reference model is compared on every falling edge,
//            and directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sin;
  logic [3:0] q;
  logic       sout;
  logic [2:0] cnt;
  logic       done;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_on   = 1'b0;

  // Reference state, kept as plain integers
  int mq, msout, mcnt, mdone;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq = 0; msout = 0; mcnt = 0; mdone = 0;
  endtask

  task automatic model_adv();
    mcnt = mcnt + 1;
    if (mcnt == 4) begin
      mcnt  = 0;
      mdone = 1;
    end
  endtask

  task automatic model_step(input bit e, input int m, input int dd, input int s);
    int old;
    old   = mq;
    mdone = 0;
    if (e) begin
      case (m)
        1: begin mq = dd; mcnt = 0; end
        2: begin msout = old / 8;  mq = (old * 2) % 16 + s;            model_adv(); end
        3: begin msout = old % 2;  mq = old / 2 + s * 8;               model_adv(); end
        4: begin msout = old / 8;  mq = (old * 2) % 16 + old / 8;      model_adv(); end
        5: begin msout = old % 2;  mq = old / 2 + (old % 2) * 8;       model_adv(); end
        6: begin mq = 0; mcnt = 0; msout = 0; end
        default: ;
      endcase
    end
  endtask

  // Drive one edge worth of inputs; returns just after the rising edge.
  task automatic step(input bit e, input int m, input int dd, input int s);
    @(negedge clk);
    #1;
    en   = e;
    mode = 3'(m);
    d    = 4'(dd);
    sin  = 1'(s);
    @(posedge clk);
    model_step(e, m, dd, s);
  endtask

  // Assert reset in the middle of a cycle and check it takes effect at once.
  task automatic do_reset();
    step(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_q",    q,    0);
    chk("rst_sout", sout, 0);
    chk("rst_cnt",  cnt,  0);
    chk("rst_done", done, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_q",    q,    mq);
      chk("model_sout", sout, msout);
      chk("model_cnt",  cnt,  mcnt);
      chk("model_done", done, mdone);
    end
  end

  initial begin
    int eq[4];
    int ec[4];
    int es[4];
    int ed[4];
    int sv[4];

    rst_n = 1'b0; en = 1'b0; mode = 3'd0; d = 4'd0; sin = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_q",    q,    0);
    chk("init_done", done, 0);
    #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Asynchronous reset after loading F
    step(1, 1, 'hF, 0);
    #1; chk("load_F", q, 'hF);
    do_reset();

    // Load and hold
    step(1, 1, 'hA, 0);
    repeat (3) step(1, 0, 0, 0);
    #1;
    chk("hold_q",    q,    'hA);
    chk("hold_cnt",  cnt,  0);
    chk("hold_done", done, 0);

    // Serial-in left after clear
    step(1, 6, 0, 0);
    sv = '{1, 0, 1, 1};
    eq = '{1, 2, 5, 'hB};
    ec = '{1, 2, 3, 0};
    ed = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 0, sv[i]);
      #1;
      chk("shl_q",    q,    eq[i]);
      chk("shl_cnt",  cnt,  ec[i]);
      chk("shl_done", done, ed[i]);
    end

    // Rotate right from 1
    step(1, 1, 1, 0);
    eq = '{8, 4, 2, 1};
    es = '{1, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      step(1, 5, 0, 0);
      #1;
      chk("ror_q",    q,    eq[i]);
      chk("ror_sout", sout, es[i]);
      chk("ror_done", done, ed[i]);
    end

    // Enable gating mid-word
    step(1, 6, 0, 0);
    step(1, 2, 0, 1);
    step(1, 2, 0, 1);
    repeat (2) step(0, 2, 0, 1);
    #1;
    chk("gate_q",    q,    3);
    chk("gate_cnt",  cnt,  2);
    chk("gate_sout", sout, 0);
    chk("gate_done", done, 0);
    step(1, 2, 0, 0);
    #1; chk("gate_done3", done, 0);
    step(1, 2, 0, 0);
    #1;
    chk("gate_done4", done, 1);
    chk("gate_q4",    q,    'hC);

    // Shift right with serial out
    step(1, 1, 'hC, 0);
    es = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      step(1, 3, 0, 0);
      #1;
      chk("shr_sout", sout, es[i]);
    end
    chk("shr_q",    q,    0);
    chk("shr_done", done, 1);

    // Load on the word-completing edge wins
    step(1, 6, 0, 0);
    repeat (3) step(1, 2, 0, 1);
    step(1, 1, 5, 0);
    #1;
    chk("prio_q",    q,    5);
    chk("prio_cnt",  cnt,  0);
    chk("prio_done", done, 0);

    // Reserved mode holds
    step(1, 7, 'hF, 1);
    #1;
    chk("rsv_q", q, 5);

    // Mixed rotate/shift directions keep counting
    step(1, 1, 9, 0);
    step(1, 4, 0, 0);
    #1; chk("rol_q", q, 3);
    step(1, 3, 0, 1);
    step(1, 5, 0, 0);
    step(1, 2, 0, 0);
    #1; chk("mix_done", done, 1);

    // Reset mid-word discards the partial count
    step(1, 2, 0, 1);
    step(1, 2, 0, 1);
    do_reset();
    repeat (3) step(1, 3, 0, 1);
    #1;
    chk("rstmid_cnt",  cnt,  3);
    chk("rstmid_done", done, 0);

    // Mixed directed sweep under model checking
    for (int i = 0; i < 48; i++) begin
      step((i % 5) != 0, i % 8, (i * 7) % 16, i % 2);
    end

    chk_on = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
`default_nettype wire
